// File: rtl/alu_operand_loader.sv
// Loads ALU operands A, B and the operation select from switches, one accepted Enter press per field.
// Optional build macro LOADER_DEBOUNCE_EN adds a DEBOUNCE_CYCLES-long debounce on the synchronized Enter level.
module alu_operand_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 32'd500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       enter,
  input  logic       clear,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [2:0] sel,
  output logic       valid,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    LOAD_A   = 2'd0,
    LOAD_B   = 2'd1,
    LOAD_SEL = 2'd2,
    DONE     = 2'd3
  } state_t;

  logic       sync1_r;
  logic       sync2_r;
  logic       prev_r;
  logic [1:0] fill_r;
  logic       armed_r;
  logic       level_s;
  logic       press_s;

  state_t     state_r, state_s;
  logic [3:0] a_r, a_s;
  logic [3:0] b_r, b_s;
  logic [2:0] sel_r, sel_s;
  logic       valid_r, valid_s;

`ifdef LOADER_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 32'd1) ? $clog2(DEBOUNCE_CYCLES) : 32'd1;
  logic             db_level_r;
  logic [CNT_W-1:0] db_cnt_r;

  // Debounce: flip the level only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level_r <= 1'b0;
      db_cnt_r   <= '0;
    end else if (sync2_r != db_level_r) begin
      if (db_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 32'd1)) begin
        db_level_r <= sync2_r;
        db_cnt_r   <= '0;
      end else begin
        db_cnt_r   <= db_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      db_cnt_r <= '0;
    end
  end

  assign level_s = db_level_r;
`else
  assign level_s = sync2_r;
`endif

  // Synchronizer, edge detector and post-reset arming of the press detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill_r  <= 2'b00;
      armed_r <= 1'b0;
    end else begin
      sync1_r <= enter;
      sync2_r <= sync1_r;
      prev_r  <= level_s;
      fill_r  <= {fill_r[0], 1'b1};
      // Only arm once the synchronizer holds a real sample of a released button,
      // so a press already in flight across reset is never taken.
      if (fill_r[1] && !sync2_r) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign press_s = level_s & ~prev_r & armed_r;

  // Next-state and next-output logic; clear outranks a press
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    sel_s   = sel_r;
    valid_s = valid_r;
    if (clear) begin
      state_s = LOAD_A;
      a_s     = 4'd0;
      b_s     = 4'd0;
      sel_s   = 3'd0;
      valid_s = 1'b0;
    end else if (press_s) begin
      case (state_r)
        LOAD_A: begin
          a_s     = sw;
          state_s = LOAD_B;
        end
        LOAD_B: begin
          b_s     = sw;
          state_s = LOAD_SEL;
        end
        LOAD_SEL: begin
          sel_s   = sw[2:0];
          valid_s = 1'b1;
          state_s = DONE;
        end
        DONE: begin
          valid_s = 1'b0;
          state_s = LOAD_A;
        end
        default: begin
          state_s = LOAD_A;
          valid_s = 1'b0;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= LOAD_A;
      a_r     <= 4'd0;
      b_r     <= 4'd0;
      sel_r   <= 3'd0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      sel_r   <= sel_s;
      valid_r <= valid_s;
    end
  end

  assign a     = a_r;
  assign b     = b_r;
  assign sel   = sel_r;
  assign valid = valid_r;
  assign phase = state_r;

endmodule

// File: doc/alu_operand_loader.md
ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 500000; number of consecutive stable cycles required before a press is accepted (10 ms at 50 MHz).
REQ-002 Clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 SW  input  4  operand/select entry switches; sampled only on an accepted press.
REQ-005 Enter  input  1  raw push-button level, active-high, asynchronous to Clock; may bounce.
REQ-006 Clear  input  1  synchronous abort, active-high, already synchronous to Clock.
REQ-007 A  output  4  latched first ALU operand.
REQ-008 B  output  4  latched second ALU operand.
REQ-009 Sel  output  3  latched ALU operation select.
REQ-010 Valid  output  1  high while A, B and Sel form a complete, consistent set.
REQ-011 Phase  output  2  current state encoding, for display on LEDs.

Function
REQ-012 Enter SHALL pass through a two-flop synchronizer before any other use.
REQ-013 An accepted press SHALL be a single-cycle pulse on the rising edge of the synchronized (and, if enabled, debounced) Enter level; holding Enter SHALL yield exactly one press.
REQ-014 The FSM SHALL have four states: LOAD_A (Phase 0), LOAD_B (1), LOAD_SEL (2), DONE (3).
REQ-015 LOAD_A + press: A <= SW[3:0], go to LOAD_B.
REQ-016 LOAD_B + press: B <= SW[3:0], go to LOAD_SEL.
REQ-017 LOAD_SEL + press: Sel <= SW[2:0], Valid <= 1, go to DONE; SW[3] is ignored.
REQ-018 DONE + press: Valid <= 0, go to LOAD_A; A, B and Sel keep their values until overwritten.
REQ-019 With no press, state and all outputs SHALL hold.
REQ-020 Clear high SHALL take priority over a press in the same cycle: A, B, Sel and Valid go to 0 and the state goes to LOAD_A on that edge.
REQ-021 With debounce disabled, an Enter level first sampled high at edge n SHALL produce updated outputs after edge n+2.
REQ-022 Valid SHALL be 1 only in DONE and SHALL never be 1 while any of A, B or Sel is mid-update.
REQ-023 SW changes outside an accepted press SHALL never alter the outputs.

Reset
REQ-024 Reset high SHALL immediately force A=0, B=0, Sel=0, Valid=0, Phase=0 (LOAD_A), and clear the synchronizer, edge-detect and debounce registers, independent of Clock.
REQ-025 Reset asserted mid-entry (any state) SHALL discard partial entries; a press in flight at reset release SHALL NOT be accepted until Enter is seen low and then high again.

Configuration
REQ-026 Macro LOADER_DEBOUNCE_EN defined: the synchronized level SHALL change only after it differs from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; the counter restarts on any mismatch glitch. Total press latency is then DEBOUNCE_CYCLES+2 edges.
REQ-027 Macro LOADER_DEBOUNCE_EN undefined: there is no debounce counter; edge detection operates directly on the synchronized level (REQ-021 latency), and DEBOUNCE_CYCLES SHALL be accepted but unused.

Verification
REQ-028 Reset, then press with SW=3, press with SW=5, press with SW=2 -> A=3, B=5, Sel=2, Valid=1, Phase=3.
REQ-029 In DONE, press -> Valid=0, Phase=0, A/B/Sel unchanged (3/5/2); next press with SW=F -> A=F, Phase=1.
REQ-030 Enter held high for 100 cycles in LOAD_A -> exactly one transition to LOAD_B.
REQ-031 Debounce enabled, DEBOUNCE_CYCLES=8: Enter toggling every 3 cycles for 30 cycles, then stable high -> exactly one press, accepted 10 edges after the level stabilizes.
REQ-032 In LOAD_SEL, Clear and a press in the same cycle -> all outputs 0, Phase=0, Valid never asserted.
REQ-033 Reset pulsed asynchronously between clock edges while in LOAD_B with Enter held high -> outputs 0 immediately; no press accepted until Enter is released and pressed again.
